// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: instruction/data memory and mul/div handshake bundle for mc_control_unit
// Signals: imem_req/imem_ready/ir_write (fetch), dmem_req/dmem_we/dmem_ready (data access),
//   muldiv_start/muldiv_op/muldiv_done (mul/div unit).
// master = control unit side, slave = memory / mul-div side.
interface mc_control_unit_if;
    logic       imem_req;
    logic       imem_ready;
    logic       ir_write;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       muldiv_start;
    logic [2:0] muldiv_op;
    logic       muldiv_done;
    modport master (
        output imem_req, ir_write, dmem_req, dmem_we, muldiv_start, muldiv_op,
        input  imem_ready, dmem_ready, muldiv_done
    );
    modport slave (
        input  imem_req, ir_write, dmem_req, dmem_we, muldiv_start, muldiv_op,
        output imem_ready, dmem_ready, muldiv_done
    );
endinterface

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I control FSM sequencing FETCH/DECODE/EXEC/MEM/WB with TRAP
// Ports: clk, rst (asynchronous, active-high); bus (mc_control_unit_if.master) for memory and
//   mul/div handshakes; opcode/funct3/funct7 from the IR; br_taken from the ALU;
//   pc_write/pc_src, alu_src/alu_op, reg_write/wb_sel to the datapath; illegal/trapped/state status.
// Build option: define CU_RV32M_EN to accept RV32M (funct7=0000001) and sequence the mul/div unit.
module mc_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    mc_control_unit_if.master bus,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              br_taken,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic [1:0]        alu_src,
    output logic [3:0]        alu_op,
    output logic              reg_write,
    output logic [1:0]        wb_sel,
    output logic              illegal,
    output logic              trapped,
    output logic [2:0]        state
);
    // a disabled timeout still needs a 1-bit counter to keep the logic well-formed
    localparam int CW = CNT_W < 1 ? 1 : CNT_W;
`ifdef CU_RV32M_EN
    localparam logic M_EN = 1'b1;
`else
    localparam logic M_EN = 1'b0;
`endif
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
    typedef enum logic [2:0] {
        FETCH = 3'b000, DECODE = 3'b001, EXEC = 3'b010, MEM = 3'b011, WB = 3'b100, TRAP = 3'b111
    } state_t;
    typedef enum logic [2:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_UPPER, C_MULDIV
    } cls_t;
    state_t        st, nxt;
    cls_t          cls, dcls;
    logic          dlegal, ready, timeout, md_done;
    logic [CW-1:0] cnt;
    logic [3:0]    rop;
`ifdef CU_RV32M_EN
    logic ex_d;
    assign md_done = bus.muldiv_done;
    always_ff @(posedge clk or posedge rst)
        if (rst) ex_d <= 1'b0;
        else ex_d <= st == EXEC;
`else
    logic unused_done;
    assign md_done = 1'b1;
    assign unused_done = bus.muldiv_done;
`endif
    always_comb begin
        dcls = C_ALU;
        dlegal = 1'b1;
        case (opcode)
            OP_R: begin
                dcls = M_EN && funct7 == 7'b0000001 ? C_MULDIV : C_ALU;
                dlegal = funct7 == 7'b0000000 || (M_EN && funct7 == 7'b0000001) ||
                         (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OP_I: dlegal = funct3 == 3'b001 ? funct7 == 7'b0000000 :
                           funct3 == 3'b101 ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1;
            OP_LOAD: dcls = C_LOAD;
            OP_STORE: dcls = C_STORE;
            OP_BRANCH: dcls = C_BRANCH;
            OP_JAL: dcls = C_JAL;
            OP_JALR: dcls = C_JALR;
            OP_LUI, OP_AUIPC: dcls = C_UPPER;
            default: dlegal = 1'b0;
        endcase
    end
    // funct7[5] selects SUB only for R-type; for shifts it selects SRA in both R and I forms
    always_comb
        case (funct3)
            3'b000: rop = opcode == OP_R && funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001: rop = ALU_SLL;
            3'b010: rop = ALU_SLT;
            3'b011: rop = ALU_SLTU;
            3'b100: rop = ALU_XOR;
            3'b101: rop = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: rop = ALU_OR;
            default: rop = ALU_AND;
        endcase
    assign ready = st == FETCH ? bus.imem_ready : bus.dmem_ready;
    assign timeout = MEM_TIMEOUT != 0 && cnt == CW'(MEM_TIMEOUT) && !ready;
    always_comb begin
        nxt = st;
        case (st)
            FETCH: nxt = ready ? DECODE : timeout ? TRAP : FETCH;
            DECODE: nxt = dlegal ? EXEC : TRAP;
            EXEC: nxt = cls == C_BRANCH ? FETCH :
                        (cls == C_LOAD || cls == C_STORE) ? MEM :
                        (cls == C_MULDIV && !md_done) ? EXEC : WB;
            MEM: nxt = ready ? (cls == C_STORE ? FETCH : WB) : timeout ? TRAP : MEM;
            WB: nxt = FETCH;
            default: nxt = TRAP;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st <= FETCH;
            cls <= C_ALU;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (st == DECODE) cls <= dcls;
            if ((nxt == FETCH || nxt == MEM) && nxt != st) cnt <= '0;
            else if ((st == FETCH || st == MEM) && !ready) cnt <= cnt + 1'b1;
        end
    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_write = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we = 1'b0;
        bus.muldiv_start = 1'b0;
        pc_write = 1'b0;
        pc_src = 2'b00;
        alu_src = 2'b00;
        alu_op = ALU_ADD;
        reg_write = 1'b0;
        wb_sel = 2'b00;
        illegal = 1'b0;
        trapped = 1'b0;
        if (!rst)
            case (st)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_write = bus.imem_ready;
                end
                DECODE: illegal = !dlegal;
                EXEC: begin
                    alu_src = cls == C_ALU ? (opcode == OP_R ? 2'b00 : 2'b01) :
                              (cls == C_LOAD || cls == C_STORE || cls == C_JALR) ? 2'b01 :
                              (cls == C_JAL || cls == C_UPPER) ? 2'b10 : 2'b00;
                    alu_op = cls == C_ALU ? rop : cls == C_BRANCH ? ALU_SUB : ALU_ADD;
                    pc_write = cls == C_BRANCH;
                    pc_src = {1'b0, cls == C_BRANCH && br_taken};
`ifdef CU_RV32M_EN
                    bus.muldiv_start = cls == C_MULDIV && !ex_d;
`endif
                end
                MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we = cls == C_STORE;
                    pc_write = cls == C_STORE && bus.dmem_ready;
                end
                WB: begin
                    reg_write = 1'b1;
                    pc_write = 1'b1;
                    wb_sel = cls == C_LOAD ? 2'b01 : (cls == C_JAL || cls == C_JALR) ? 2'b10 :
                             cls == C_MULDIV ? 2'b11 : 2'b00;
                    pc_src = cls == C_JAL ? 2'b01 : cls == C_JALR ? 2'b10 : 2'b00;
                end
                TRAP: trapped = 1'b1;
                default: ;
            endcase
    end
    assign bus.muldiv_op = rst ? 3'b000 : funct3;
    assign state = st;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed instruction sequences scored cycle-by-cycle against a timing model
module tb_mc_control_unit;
    localparam int TO = 4;
`ifdef CU_RV32M_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif
    typedef enum {K_ALU, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_UP, K_MD} kind_t;
    typedef struct {
        bit         legal;
        bit         chk;
        kind_t      k;
        logic [1:0] asrc;
        logic [3:0] aop;
    } info_t;
    typedef struct packed {
        logic       chk;
        logic [2:0] st;
        logic       imem_req, ir_write, dmem_req, dmem_we, pc_write;
        logic [1:0] pc_src, alu_src;
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal, trapped, mstart;
        logic [2:0] mop;
    } rec_t;
    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic       br_taken = 1'b0;
    logic       pc_write, reg_write, illegal, trapped;
    logic [1:0] pc_src, alu_src, wb_sel;
    logic [3:0] alu_op;
    logic [2:0] state;
    rec_t       q[$];
    int         checks = 0, passed = 0, cyc = 0;
    string      tag = "reset";
    mc_control_unit_if bus();
    mc_control_unit #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_taken(br_taken), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
        .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal),
        .trapped(trapped), .state(state)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        rec_t e, a;
        cyc++;
        if (q.size() != 0) begin
            e = q.pop_front();
            a = '0;
            a.chk = e.chk;
            a.st = state;
            a.imem_req = bus.imem_req;
            a.ir_write = bus.ir_write;
            a.dmem_req = bus.dmem_req;
            a.dmem_we = bus.dmem_we;
            a.pc_write = pc_write;
            a.pc_src = pc_src;
            a.reg_write = reg_write;
            a.wb_sel = wb_sel;
            a.illegal = illegal;
            a.trapped = trapped;
            a.mstart = bus.muldiv_start;
            a.mop = bus.muldiv_op;
            if (e.chk) begin
                a.alu_src = alu_src;
                a.alu_op = alu_op;
            end
            checks++;
            if (a === e) passed++;
            else $display("FAIL %s cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                          tag, cyc, a.st, a, e.st, e);
        end
    end
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic lit(input string nm, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input bit alt);
        case (f3)
            3'd0: return alt ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction
    function automatic info_t classify(input logic [31:0] ir);
        info_t d;
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = ir[6:0];
        f3 = ir[14:12];
        f7 = ir[31:25];
        d.legal = 1'b1;
        d.chk = 1'b1;
        d.k = K_ALU;
        d.asrc = 2'b00;
        d.aop = 4'd0;
        case (op)
            7'h33: begin
                d.legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                          (MEXT && f7 == 7'h01);
                d.aop = alu_of(f3, f7 == 7'h20);
                if (f7 == 7'h01) begin
                    d.k = K_MD;
                    d.chk = 1'b0;
                end
            end
            7'h13: begin
                if (f3 == 3'd1) d.legal = f7 == 7'h00;
                if (f3 == 3'd5) d.legal = f7 == 7'h00 || f7 == 7'h20;
                d.asrc = 2'b01;
                d.aop = alu_of(f3, f3 == 3'd5 && f7 == 7'h20);
            end
            7'h03: begin d.k = K_LD; d.asrc = 2'b01; end
            7'h23: begin d.k = K_ST; d.asrc = 2'b01; end
            7'h63: begin d.k = K_BR; d.aop = 4'd1; end
            7'h6f: begin d.k = K_JAL; d.chk = 1'b0; end
            7'h67: begin d.k = K_JALR; d.chk = 1'b0; end
            7'h37, 7'h17: begin d.k = K_UP; d.asrc = 2'b10; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction
    function automatic rec_t mk(input logic [2:0] s);
        rec_t r;
        r = '0;
        r.st = s;
        r.mop = funct3;
        return r;
    endfunction
    task automatic tick(input logic [31:0] ir, input bit ir_rdy, dr, bt, md);
        @(posedge clk);
        #1;
        rst = 1'b0;
        opcode = ir[6:0];
        funct3 = ir[14:12];
        funct7 = ir[31:25];
        bus.imem_ready = ir_rdy;
        bus.dmem_ready = dr;
        br_taken = bt;
        bus.muldiv_done = md;
    endtask
    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            bus.imem_ready = 1'b0;
            bus.dmem_ready = 1'b0;
            bus.muldiv_done = 1'b0;
            q.push_back('0);
        end
    endtask
    task automatic trap_tail(input logic [31:0] ir);
        rec_t r;
        for (int i = 0; i < 3; i++) begin
            tick(ir, 1'b1, 1'b1, 1'b1, 1'b1);
            r = mk(3'd7);
            r.trapped = 1'b1;
            q.push_back(r);
        end
        rst_cycles(2);
    endtask
    task automatic run(input string name, input logic [31:0] ir, input int is, ds,
                       input bit bt, input int md, input bit abort, output int n);
        info_t d;
        rec_t r;
        bit rdy;
        d = classify(ir);
        n = 0;
        tag = name;
        for (int i = 0; i <= is; i++) begin
            rdy = i == is;
            tick(ir, rdy, 1'b0, 1'b0, 1'b0);
            r = mk(3'd0);
            r.imem_req = 1'b1;
            r.ir_write = rdy;
            q.push_back(r);
            n++;
            if (!rdy && TO != 0 && i == TO) begin
                trap_tail(ir);
                return;
            end
        end
        tick(ir, 1'b0, 1'b0, 1'b0, 1'b0);
        r = mk(3'd1);
        r.illegal = !d.legal;
        q.push_back(r);
        n++;
        if (!d.legal) begin
            trap_tail(ir);
            return;
        end
        if (d.k == K_MD) begin
            for (int i = 0; i <= md; i++) begin
                tick(ir, 1'b0, 1'b0, 1'b0, i == md);
                r = mk(3'd2);
                r.mstart = i == 0;
                q.push_back(r);
                n++;
            end
        end else begin
            tick(ir, 1'b0, 1'b0, bt, 1'b0);
            r = mk(3'd2);
            r.chk = d.chk;
            r.alu_src = d.chk ? d.asrc : 2'b00;
            r.alu_op = d.chk ? d.aop : 4'd0;
            if (d.k == K_BR) begin
                r.pc_write = 1'b1;
                r.pc_src = bt ? 2'b01 : 2'b00;
            end
            q.push_back(r);
            n++;
            if (d.k == K_BR) return;
        end
        if (d.k == K_LD || d.k == K_ST) begin
            for (int i = 0; i <= ds; i++) begin
                if (abort && i == 2) begin
                    @(posedge clk);
                    #1;
                    bus.dmem_ready = 1'b0;
                    lit("pre_rst_state_mem", int'(state), 3);
                    #2;
                    rst = 1'b1;
                    #1;
                    lit("async_rst_state", int'(state), 0);
                    lit("async_rst_dmem_req", int'(bus.dmem_req), 0);
                    lit("async_rst_pc_write", int'(pc_write), 0);
                    lit("async_rst_reg_write", int'(reg_write), 0);
                    rst_cycles(2);
                    return;
                end
                rdy = i == ds;
                tick(ir, 1'b0, rdy, 1'b0, 1'b0);
                r = mk(3'd3);
                r.dmem_req = 1'b1;
                r.dmem_we = d.k == K_ST;
                r.pc_write = d.k == K_ST && rdy;
                q.push_back(r);
                n++;
                if (!rdy && TO != 0 && i == TO) begin
                    trap_tail(ir);
                    return;
                end
            end
            if (d.k == K_ST) return;
        end
        tick(ir, 1'b0, 1'b0, 1'b0, 1'b0);
        r = mk(3'd4);
        r.reg_write = 1'b1;
        r.pc_write = 1'b1;
        r.wb_sel = d.k == K_LD ? 2'b01 : (d.k == K_JAL || d.k == K_JALR) ? 2'b10 :
                   d.k == K_MD ? 2'b11 : 2'b00;
        r.pc_src = d.k == K_JAL ? 2'b01 : d.k == K_JALR ? 2'b10 : 2'b00;
        q.push_back(r);
        n++;
    endtask
    initial begin
        int n;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.muldiv_done = 1'b0;
        rst_cycles(2);
        run("add", 32'h00208033, 0, 0, 1'b0, 0, 1'b0, n);
        lit("add_cycles", n, 4);
        run("lw_ds3", 32'h0000a083, 0, 3, 1'b0, 0, 1'b0, n);
        lit("lw_ds3_cycles", n, 8);
        run("beq_taken", 32'h00208063, 0, 0, 1'b1, 0, 1'b0, n);
        lit("beq_taken_cycles", n, 3);
        run("beq_not_taken", 32'h00208063, 0, 0, 1'b0, 0, 1'b0, n);
        lit("beq_not_taken_cycles", n, 3);
        run("sw", 32'h0020a023, 0, 0, 1'b0, 0, 1'b0, n);
        lit("sw_cycles", n, 4);
        run("lw", 32'h0000a083, 0, 0, 1'b0, 0, 1'b0, n);
        lit("lw_cycles", n, 5);
        run("sub_is1", 32'h40208033, 1, 0, 1'b0, 0, 1'b0, n);
        lit("sub_is1_cycles", n, 5);
        run("sra", 32'h4020d033, 0, 0, 1'b0, 0, 1'b0, n);
        run("xor", 32'h0020c033, 0, 0, 1'b0, 0, 1'b0, n);
        run("sltu", 32'h0020b033, 0, 0, 1'b0, 0, 1'b0, n);
        run("addi_is2", 32'h00500093, 2, 0, 1'b0, 0, 1'b0, n);
        lit("addi_is2_cycles", n, 6);
        run("srai", 32'h4050d093, 0, 0, 1'b0, 0, 1'b0, n);
        run("jal", 32'h008000ef, 0, 0, 1'b0, 0, 1'b0, n);
        lit("jal_cycles", n, 4);
        run("jalr", 32'h000080e7, 0, 0, 1'b0, 0, 1'b0, n);
        run("lui", 32'h123450b7, 0, 0, 1'b0, 0, 1'b0, n);
        run("auipc", 32'h00001097, 0, 0, 1'b0, 0, 1'b0, n);
        run("sw_ds2", 32'h0020a023, 0, 2, 1'b0, 0, 1'b0, n);
        lit("sw_ds2_cycles", n, 6);
        run("lw_edge", 32'h0000a083, TO, TO, 1'b0, 0, 1'b0, n);
        lit("lw_edge_cycles", n, 5 + 2 * TO);
        run("mul", 32'h02208033, 0, 0, 1'b0, 5, 1'b0, n);
        lit("mul_cycles", n, MEXT ? 9 : 2);
        run("r_funct7_bad", 32'h40209033, 0, 0, 1'b0, 0, 1'b0, n);
        run("slli_bad", 32'h40509093, 0, 0, 1'b0, 0, 1'b0, n);
        run("opcode_7f", 32'h0000007f, 0, 0, 1'b0, 0, 1'b0, n);
        lit("opcode_7f_cycles", n, 2);
        run("imem_timeout", 32'h00208033, 10, 0, 1'b0, 0, 1'b0, n);
        lit("imem_timeout_fetch_cycles", n, TO + 1);
        run("dmem_timeout", 32'h0000a083, 0, 10, 1'b0, 0, 1'b0, n);
        lit("dmem_timeout_cycles", n, TO + 4);
        run("rst_mid_mem", 32'h0000a083, 0, 10, 1'b0, 0, 1'b1, n);
        run("add_after_rst", 32'h00208033, 0, 0, 1'b0, 0, 1'b0, n);
        lit("add_after_rst_cycles", n, 4);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control unit for the RV32I core; successor to the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It handshakes with instruction and data memories that may stall, and drives the same ALU operation encoding as the single-cycle core. It sits between the instruction register and the datapath muxes, PC register, register file and memories. Illegal encodings and memory timeouts trap.

## Interface
- MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before TRAP; 0 disables timeout
- CNT_W, $clog2(MEM_TIMEOUT+1), timeout counter width (derived, do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0], stable from DECODE until next FETCH
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- br_taken  in  1  branch comparison result from ALU, valid in EXEC
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- ir_write  out  1  latch instruction into IR
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ready  in  1  data access completes this cycle
- muldiv_start  out  1  one-cycle start pulse (macro only, else tied 0)
- muldiv_op  out  3  funct3 passthrough for mul/div unit
- muldiv_done  in  1  mul/div result valid (ignored without macro)
- pc_write  out  1  update PC
- pc_src  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result (JALR)
- alu_src  out  2  00 rs2, 01 imm, 10 PC/upper-imm
- alu_op  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 ALU, 01 load data, 10 PC+4, 11 mul/div result
- illegal  out  1  pulses in the DECODE cycle of an illegal instruction
- trapped  out  1  high while in TRAP
- state  out  3  FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, TRAP 111

## Operation
- State register, timeout counter and captured decode class are flops. Outputs are a combinational function of state and the IR fields.
- All outputs are forced to 0 while rst is high. After reset: state = FETCH, counter = 0.
- FETCH: imem_req=1 until imem_ready. On imem_ready: ir_write=1 and go to DECODE.
- DECODE: classify the instruction.
  - Illegal encodings: unknown opcode; R-type funct7 other than 0000000/0100000; funct7=0100000 with funct3 other than 000/101; SLLI with funct7≠0; SRLI/SRAI with funct7 other than 0000000/0100000.
  - Illegal: illegal=1, go to TRAP. Otherwise go to EXEC.
- EXEC: alu_src/alu_op are driven per class, with the same mapping as the single-cycle decoder. Branch uses SUB. LUI/AUIPC use alu_src=10 and ADD.
  - Branch: pc_write=1; pc_src=01 if br_taken, else 00; go to FETCH.
  - Load/store: go to MEM.
  - All other classes: go to WB.
- MEM: dmem_req=1, dmem_we per class, held until dmem_ready.
  - Store done: pc_write=1, pc_src=00, go to FETCH.
  - Load done: go to WB.
- WB: reg_write=1, pc_write=1, then go to FETCH.
  - wb_sel: 01 for load, 10 for JAL/JALR, 00 otherwise.
  - pc_src: 01 for JAL, 10 for JALR, 00 otherwise.
- Timeout: the counter clears on entry to FETCH or MEM and increments each cycle that ready is low. When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with ready still low, go to TRAP. Ready arriving in that same cycle wins.
- TRAP: all enables 0, trapped=1. The block stays in TRAP until rst.

## Timing
- Zero-wait memory, cycles per instruction: ALU/LUI/AUIPC/JAL/JALR 4, branch 3, store 4, load 5.
- Each cycle of imem/dmem stall adds one cycle. The request stays high and the other outputs are stable throughout.
- pc_write and reg_write are asserted for exactly one cycle per instruction. ir_write is asserted for exactly one cycle per fetch.
- Reset asserted mid-instruction: state returns to FETCH immediately (asynchronously). No write enable is asserted on or after the reset edge.

## Configuration
- CU_RV32M_EN defined:
  - R-type with funct7=0000001 is legal.
  - On EXEC entry, muldiv_start pulses for 1 cycle and muldiv_op=funct3.
  - EXEC holds until muldiv_done, then goes to WB with wb_sel=11. No timeout applies in EXEC.
- CU_RV32M_EN undefined: funct7=0000001 is illegal; muldiv_start=0; muldiv_done is ignored.

## Test plan
- Reset, then ADD (0x00208033) with imem_ready=1 -> states 000,001,010,100. In EXEC alu_op=0000, alu_src=00. In WB reg_write=1, wb_sel=00, pc_write=1, pc_src=00.
- LW, dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles. Then WB with wb_sel=01. Total 8 cycles.
- BEQ with br_taken=1, then again with 0 -> 3 cycles each; pc_write=1 in EXEC with pc_src=01, then 00.
- Opcode 0x7F -> illegal=1 in DECODE, then state=111, trapped=1. No further requests until rst.
- MEM_TIMEOUT=4, imem_ready held 0 -> TRAP after 4 stalled cycles. Assert rst mid-MEM on a separate run -> state=000 asynchronously, dmem_req=0.
- With CU_RV32M_EN, MUL (funct7=0000001), muldiv_done after 5 cycles -> muldiv_start for 1 cycle, EXEC held 6 cycles, WB with wb_sel=11. Without the macro the same instruction traps.
